conf_chain_driver: RTL

//  Upstream feeder for the tile configuration latch chain (CONFin/CONFout daisy chain).
//  - Takes configuration words over a valid/ready stream.
//  - Serialises each word MSB-first onto CONF_DATA.
//  - Generates two non-overlapping latch-enable strobes: CONF_PH1 (drives chain CLK, odd latches)
//    and CONF_PH2 (drives chain MODE, even latches). One PH1+PH2 pair shifts the chain by one bit.
//  - Sits between the bitstream source and the first tile's CONFin.

---
 rtl/conf_chain_driver.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/conf_chain_driver.sv
// conf_chain_driver
// Feeds the tile configuration latch chain. Each accepted word is sent MSB-first
// on CONF_DATA. Every bit gets one CONF_PH1 strobe and then one CONF_PH2 strobe.
// The two strobes never overlap, and dead cycles sit on both sides of each strobe.
// All outputs come straight from flops.
// Optional feature: define CONF_READBACK_EN to add chain readback. This adds the
// CONF_RET input, the rb_data output and the rb_valid output.

module conf_chain_driver #(
  parameter int DATA_W    = 32,
  parameter int PULSE_CYC = 1,
  parameter int GAP_CYC   = 1
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic              busy,
  output logic              done,
  output logic              CONF_DATA,
  output logic              CONF_PH1,
  output logic              CONF_PH2
`ifdef CONF_READBACK_EN
  ,
  input  logic              CONF_RET,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_valid
`endif
);

  localparam int BW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int TMAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int TW   = $clog2(TMAX) + 1;

  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYC - 1);
  localparam logic [TW-1:0] TMR_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);
  localparam logic [BW-1:0] MSB_IDX  = BW'(DATA_W - 1);
  localparam logic [BW-1:0] BIT_ZERO = {BW{1'b0}};
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PH1   = 3'd2,
    ST_GAP1  = 3'd3,
    ST_PH2   = 3'd4,
    ST_GAP2  = 3'd5,
    ST_WAIT  = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              last_q, last_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic              s_ready_q, s_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              data_q, data_d;
  logic              ph1_q, ph1_d;
  logic              ph2_q, ph2_d;
  logic              gap2_end;

  // The final cycle of GAP2 closes a bit period.
  assign gap2_end = (state_q == ST_GAP2) && (tmr_q == TMR_ZERO);

  // Next state and counters. Outputs are decoded from the next state so they line up with it.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    last_d    = last_q;
    bit_cnt_d = bit_cnt_q;
    tmr_d     = tmr_q;
    data_d    = data_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE, ST_WAIT: begin
        if (s_valid && s_ready_q) begin
          word_d    = s_data;
          last_d    = s_last;
          bit_cnt_d = MSB_IDX;
          data_d    = s_data[DATA_W-1];
          state_d   = ST_SETUP;
        end else begin
          state_d = state_q;
        end
      end
      ST_SETUP: begin
        tmr_d   = PULSE_LD;
        state_d = ST_PH1;
      end
      ST_PH1: begin
        if (tmr_q == TMR_ZERO) begin
          tmr_d   = GAP_LD;
          state_d = ST_GAP1;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      ST_GAP1: begin
        if (tmr_q == TMR_ZERO) begin
          tmr_d   = PULSE_LD;
          state_d = ST_PH2;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      ST_PH2: begin
        if (tmr_q == TMR_ZERO) begin
          tmr_d   = GAP_LD;
          state_d = ST_GAP2;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      ST_GAP2: begin
        if (gap2_end) begin
          if (bit_cnt_q != BIT_ZERO) begin
            bit_cnt_d = bit_cnt_q - BIT_ONE;
            data_d    = word_q[bit_cnt_d];
            state_d   = ST_SETUP;
          end else if (last_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    s_ready_d = (state_d == ST_IDLE) || (state_d == ST_WAIT);
    busy_d    = !s_ready_d;
    ph1_d     = (state_d == ST_PH1);
    ph2_d     = (state_d == ST_PH2);
  end

  // State and output registers. Reset is immediate, so the strobes drop as soon as RESETn falls.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q   <= ST_IDLE;
      word_q    <= {DATA_W{1'b0}};
      last_q    <= 1'b0;
      bit_cnt_q <= BIT_ZERO;
      tmr_q     <= TMR_ZERO;
      s_ready_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      data_q    <= 1'b0;
      ph1_q     <= 1'b0;
      ph2_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      last_q    <= last_d;
      bit_cnt_q <= bit_cnt_d;
      tmr_q     <= tmr_d;
      s_ready_q <= s_ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      data_q    <= data_d;
      ph1_q     <= ph1_d;
      ph2_q     <= ph2_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign CONF_DATA = data_q;
  assign CONF_PH1  = ph1_q;
  assign CONF_PH2  = ph2_q;

`ifdef CONF_READBACK_EN
  logic [DATA_W-1:0] rb_data_q, rb_data_d;
  logic              rb_valid_q, rb_valid_d;

  // Shift the chain return in at the end of every bit, and flag a complete word after its last bit.
  always_comb begin
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;
    if (gap2_end) begin
      rb_data_d  = {rb_data_q[DATA_W-2:0], CONF_RET};
      rb_valid_d = (bit_cnt_q == BIT_ZERO);
    end else begin
      rb_data_d  = rb_data_q;
    end
  end

  // Readback registers.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rb_data_q  <= {DATA_W{1'b0}};
      rb_valid_q <= 1'b0;
    end else begin
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;
`endif

endmodule
